// File: rtl/seven_segment_pkg.sv
// Shared segment encoding for the seven-segment scanner: active-high hex table,
// the all-off pattern and the bit positions within {a,b,c,d,e,f,g,dp}.
package seven_segment_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// Nibble to active-high segment pattern; blank suppresses a..g but leaves the dot
// under caller control so leading-zero positions can still show a decimal point.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [7:0] hex;

    always_comb begin
        hex     = HEX_SEG[nibble];
        pattern = SEG_OFF;
        if (!blank) begin
            pattern[SEG_A:SEG_G] = hex[SEG_A:SEG_G];
        end
        pattern[SEG_DP] = dot;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with per-slot dwell, leading blanking, PWM
// brightness, frame-coherent input snapshot and leading-zero suppression.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int DWELL      = 4,
    parameter int BLANK      = 1,
    parameter int ACTIVE_LOW = 1,
    parameter int BRIGHT_W   = 2
) (
    input  logic                  clk_8KHz,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digit,
    input  logic [N_DIGITS-1:0]   en_dot,
    input  logic [N_DIGITS-1:0]   en_digit,
    input  logic                  lzb,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   pos,
    output logic [7:0]            segments,
    output logic                  frame_start
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int LW = $clog2(DWELL) + BRIGHT_W + 1;

    logic [IW-1:0]         idx_p0, idx_nxt;
    logic [DW-1:0]         dwell_p0, dwell_nxt;
    logic                  vld_p0;
    logic [4*N_DIGITS-1:0] sh_digit_p0;
    logic [N_DIGITS-1:0]   sh_dot_p0;
    logic [N_DIGITS-1:0]   sh_en_p0;
    logic                  sh_lzb_p0;

    logic [3:0]            nib_sel;
    logic                  dot_sel;
    logic                  en_sel;
    logic                  lz_sel;
    logic                  lit;
    int                    r;
    logic [7:0]            pattern;
    logic [N_DIGITS-1:0]   pos_act;
    logic [7:0]            seg_act;

    function automatic logic [LW-1:0] lit_len_f(input logic [BRIGHT_W-1:0] b);
        logic [LW-1:0] prod;
        prod = LW'(DWELL - BLANK) * (LW'(b) + LW'(1));
        prod = prod >> BRIGHT_W;
        if (prod == '0) begin
            prod = LW'(1);
        end
        return prod;
    endfunction

    function automatic logic upper_zero(input logic [4*N_DIGITS-1:0] d, input logic [IW-1:0] k);
        logic z;
        z = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(k) && d[4*j +: 4] != 4'h0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

    function automatic logic [N_DIGITS-1:0] pin_pos(input logic [N_DIGITS-1:0] p);
        return (ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    function automatic logic [7:0] pin_seg(input logic [7:0] s);
        return (ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    always_comb begin
        idx_nxt   = idx_p0;
        dwell_nxt = dwell_p0 + DW'(1);
        if (dwell_p0 == DW'(DWELL - 1)) begin
            dwell_nxt = '0;
            idx_nxt   = (idx_p0 == IW'(N_DIGITS - 1)) ? '0 : idx_p0 + IW'(1);
        end
    end

    // Stage p0: scan position and the frame snapshot taken when entering (0,0)
    always_ff @(posedge clk_8KHz) begin
        if (rst) begin
            idx_p0      <= IW'(N_DIGITS - 1);
            dwell_p0    <= DW'(DWELL - 1);
            vld_p0      <= 1'b0;
            sh_digit_p0 <= '0;
            sh_dot_p0   <= '0;
            sh_en_p0    <= '0;
            sh_lzb_p0   <= 1'b0;
        end else begin
            idx_p0   <= idx_nxt;
            dwell_p0 <= dwell_nxt;
            vld_p0   <= 1'b1;
            if (idx_nxt == '0 && dwell_nxt == '0) begin
                sh_digit_p0 <= digit;
                sh_dot_p0   <= en_dot;
                sh_en_p0    <= en_digit;
                sh_lzb_p0   <= lzb;
            end
        end
    end

    always_comb begin
        nib_sel = 4'h0;
        dot_sel = 1'b0;
        en_sel  = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IW'(j) == idx_p0) begin
                nib_sel = sh_digit_p0[4*j +: 4];
                dot_sel = sh_dot_p0[j];
                en_sel  = sh_en_p0[j];
            end
        end
        lz_sel = sh_lzb_p0 && (idx_p0 != '0) && upper_zero(sh_digit_p0, idx_p0);
    end

    seven_segment_decoder u_decoder (
        .nibble  (nib_sel),
        .dot     (dot_sel & en_sel),
        .blank   (!en_sel || lz_sel),
        .pattern (pattern)
    );

    // Lit window: BLANK dead cycles, then lit_len cycles, then dark for the rest
    always_comb begin
        r       = int'(dwell_p0) - BLANK;
        lit     = vld_p0 && (r >= 0) && (r < int'(lit_len_f(brightness)));
        pos_act = lit ? (N_DIGITS'(1) << idx_p0) : '0;
        seg_act = lit ? pattern : SEG_OFF;
    end

    // Stage p1: registered pins at board polarity
    always_ff @(posedge clk_8KHz) begin
        if (rst) begin
            pos         <= pin_pos('0);
            segments    <= pin_seg(SEG_OFF);
            frame_start <= 1'b0;
        end else begin
            pos         <= pin_pos(pos_act);
            segments    <= pin_seg(seg_act);
            frame_start <= vld_p0 && (idx_p0 == '0) && (dwell_p0 == '0);
        end
    end

endmodule
